pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Generic parametrised pipeline-stage register. Successor to the fixed-field
//  stage registers (if/id, id/ex, ex/mem, mem/wb). Payload is one flat bus.
//  Uses a valid/ready handshake in place of stall vectors.
//  Optional 2-entry skid buffer so in_ready is registered.
//  Synchronous flush for exceptions; saturating stall counter for perf debug.
// PARAMETERS
//  PAYLOAD_W  198  payload width (packed stage fields, e.g. pc/aluop/wdata)
//  CNT_W      16   width of stall_cycles counter
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          async reset, active-low
//  flush         in   1          sync kill of all held entries (exception)
//  clr_cnt       in   1          sync clear of stall_cycles
//  in_valid      in   1          upstream holds a valid payload
//  in_ready      out  1          stage accepts payload this cycle
//  in_payload    in   PAYLOAD_W  upstream payload
//  out_valid     out  1          out_payload is valid
//  out_ready     in   1          downstream accepts this cycle
//  out_payload   out  PAYLOAD_W  head entry
//  occupancy     out  2          entries held: 0, 1 or 2
//  stall_cycles  out  CNT_W      cycles with out_valid & !out_ready
// BEHAVIOUR
//  - Fire terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Storage: main reg M drives out_payload. Skid reg S is used only when the
//    macro below is defined. State EMPTY=0, ONE=1, FULL=2; occupancy = state.
//  - Reset (rst=0, async): state=EMPTY, M=S=0, out_valid=0, in_ready=0,
//    stall_cycles=0. in_ready goes to 1 on the first clk edge after release.
//  - Latency: payload accepted on edge N appears on out_payload after edge N.
//    Minimum 1 cycle. Strict FIFO order; no loss, no duplication.
//  - out_valid = (state != EMPTY). out_payload = M when valid, else 0.
//  - Transitions (no flush):
//    EMPTY: in_fire -> ONE, M<=in_payload.
//    ONE: in_fire & out_fire -> ONE, M<=in_payload.
//    ONE: in_fire & !out_fire -> FULL, S<=in_payload.
//    ONE: !in_fire & out_fire -> EMPTY, M<=0.
//    FULL: out_fire -> ONE, M<=S, S<=0. in_fire cannot occur (in_ready=0).
//  - Flush: highest priority after reset. Next state EMPTY, M=S=0.
//    An in_fire or out_fire in the flush cycle is discarded upstream-side.
//    Downstream still sees the handshake but must ignore it (it is flushed too).
//    in_ready=1 the cycle after flush. stall_cycles is unaffected.
//  - stall_cycles: +1 each edge where out_valid & !out_ready. Saturates at
//    2^CNT_W-1 (no wrap). clr_cnt forces 0 and takes priority over increment.
//  - Payload content is opaque. No field decode or width conversion.
// CONFIGURATION
//  PIPE_SKID_EN defined:
//    2-entry skid as above.
//    in_ready is a flop: next value = (next_state != FULL).
//    No combinational path from out_ready to in_ready.
//    Full throughput under any out_ready pattern.
//  PIPE_SKID_EN undefined:
//    S is removed and FULL is unreachable; occupancy is at most 1.
//    in_ready = (state==EMPTY) | out_ready, combinational.
//    Exception: in_ready is held 0 while rst is asserted and on the first cycle
//    after release, identical to the skid case.
//    Latency, flush and counter behaviour are unchanged.
// TESTING (PAYLOAD_W=32 unless stated)
//  1. rst=0 with in_valid=1 -> out_valid=0, out_payload=0, in_ready=0,
//     occupancy=0. Release -> in_ready=1 after the first edge.
//  2. out_ready=1; push 0x11,0x22,0x33 on consecutive edges -> out_payload
//     0x11,0x22,0x33 one edge later each; occupancy=1; stall_cycles=0.
//  3. out_ready=0; push 0xA0,0xA1 -> occupancy=2, in_ready=0, out_payload=0xA0.
//     Hold 0xA2 on input, then out_ready=1 -> 0xA0,0xA1,0xA2 in order;
//     stall_cycles equals the held cycles.
//  4. FULL state, flush=1 with in_valid=1, in_payload=0xBB -> next cycle
//     occupancy=0, out_valid=0, out_payload=0, in_ready=1; 0xBB never emitted.
//  5. CNT_W=4; out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15
//     (saturated). clr_cnt=1 -> 0.
//  6. PIPE_SKID_EN undefined; 0xC0 held, out_ready=0 -> in_ready=0 the same
//     cycle. out_ready=1 with in_valid=1, in_payload=0xC1 -> 0xC0 drains,
//     0xC1 captured, occupancy stays 1.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- generic valid/ready pipeline-stage register.
// The payload is one opaque flat bus; the main register M always drives
// out_payload and is zero whenever the stage is empty.
// Optional feature macro: PIPE_SKID_EN
//   defined   : 2-entry skid buffer (M + S), in_ready comes straight from a flop,
//               no combinational path from out_ready to in_ready.
//   undefined : single entry, in_ready = (state==EMPTY) | out_ready.
// A synchronous flush kills every held entry; stall_cycles is a saturating
// count of cycles where the head entry waits on downstream.

module pipe_stage_buf #(
  parameter int PAYLOAD_W = 198,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 clr_cnt,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [PAYLOAD_W-1:0] PAYLOAD_ZERO = {PAYLOAD_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_MAX      = {CNT_W{1'b1}};

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] m_q, m_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_fire, out_fire;

`ifdef PIPE_SKID_EN
  logic [PAYLOAD_W-1:0] s_q, s_d;
  logic                 in_ready_q, in_ready_d;
`else
  // Holds in_ready low through reset and the first cycle after release.
  logic                 rdy_en_q;
`endif

  assign in_fire      = in_valid & in_ready;
  assign out_fire     = valid_q & out_ready;
  assign out_valid    = valid_q;
  assign out_payload  = m_q;
  assign occupancy    = state_q;
  assign stall_cycles = cnt_q;

  // State register: FSM state, storage and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      m_q        <= PAYLOAD_ZERO;
      valid_q    <= 1'b0;
`ifdef PIPE_SKID_EN
      s_q        <= PAYLOAD_ZERO;
      in_ready_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      valid_q    <= valid_d;
`ifdef PIPE_SKID_EN
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
`endif
    end
  end

`ifndef PIPE_SKID_EN
  // Ready enable: becomes 1 on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end
`endif

  // Stall counter register: saturating count of cycles the head waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next-state logic: flush wins, otherwise move entries per the handshakes.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
`ifdef PIPE_SKID_EN
    s_d     = s_q;
`endif
    if (flush) begin
      // Any fire in this cycle is dropped; both entries are cleared.
      state_d = ST_EMPTY;
      m_d     = PAYLOAD_ZERO;
`ifdef PIPE_SKID_EN
      s_d     = PAYLOAD_ZERO;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            m_d     = in_payload;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            // Head leaves and the new payload takes its place.
            state_d = ST_ONE;
            m_d     = in_payload;
          end else if (in_fire) begin
`ifdef PIPE_SKID_EN
            // Downstream stalled: park the new payload in the skid slot.
            state_d = ST_FULL;
            s_d     = in_payload;
`else
            // Cannot happen: in_ready implies out_ready while holding one.
            state_d = ST_ONE;
`endif
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            m_d     = PAYLOAD_ZERO;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
`ifdef PIPE_SKID_EN
          // in_ready is 0 here, so only the head can move.
          if (out_fire) begin
            state_d = ST_ONE;
            m_d     = s_q;
            s_d     = PAYLOAD_ZERO;
          end else begin
            state_d = ST_FULL;
          end
`else
          // Unreachable without the skid slot; recover to a clean empty stage.
          state_d = ST_EMPTY;
          m_d     = PAYLOAD_ZERO;
`endif
        end
        default: begin
          state_d = ST_EMPTY;
          m_d     = PAYLOAD_ZERO;
`ifdef PIPE_SKID_EN
          s_d     = PAYLOAD_ZERO;
`endif
        end
      endcase
    end
  end

  // Output logic: next valid/ready values and the stall counter update.
  always_comb begin
    valid_d = (state_d != ST_EMPTY);
`ifdef PIPE_SKID_EN
    in_ready_d = (state_d != ST_FULL);
    in_ready   = in_ready_q;
`else
    in_ready   = rdy_en_q & ((state_q == ST_EMPTY) | out_ready);
`endif
    if (clr_cnt) begin
      cnt_d = CNT_ZERO;
    end else if (valid_q && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (PAYLOAD_W=32, CNT_W=4).
// Expected values are hand-computed; the skid and single-entry builds each
// get their own directed sequence for the FULL-state and in_ready checks.

module tb_pipe_stage_buf;

  localparam int PW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          clr_cnt;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_payload;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_stage_buf #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .clr_cnt      (clr_cnt),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_payload   (in_payload),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_payload  (out_payload),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset with in_valid high
    rst = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    in_valid = 1'b1; in_payload = 32'h55; out_ready = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_payload", out_payload, 32'h0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_stall", {28'd0, stall_cycles}, 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("release_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    tick();
    check("release_in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // 2. Streaming with out_ready=1
    out_ready = 1'b1;
    in_valid = 1'b1; in_payload = 32'h11;
    tick();
    check("stream_0x11", out_payload, 32'h11);
    check("stream_occ", {30'd0, occupancy}, 32'd1);
    in_payload = 32'h22;
    tick();
    check("stream_0x22", out_payload, 32'h22);
    in_payload = 32'h33;
    tick();
    check("stream_0x33", out_payload, 32'h33);
    check("stream_occ2", {30'd0, occupancy}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("stream_drained_valid", {31'd0, out_valid}, 32'd0);
    check("stream_drained_payload", out_payload, 32'h0);
    check("stream_stall", {28'd0, stall_cycles}, 32'd0);

`ifdef PIPE_SKID_EN
    // 3. Skid fill and ordered drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = 32'hA0;
    tick();
    in_payload = 32'hA1;
    tick();
    check("skid_occ_full", {30'd0, occupancy}, 32'd2);
    check("skid_in_ready_full", {31'd0, in_ready}, 32'd0);
    check("skid_head_a0", out_payload, 32'hA0);
    in_payload = 32'hA2;
    tick();
    check("skid_hold_head", out_payload, 32'hA0);
    check("skid_stall_held", {28'd0, stall_cycles}, 32'd2);
    out_ready = 1'b1;
    tick();
    check("skid_drain_a1", out_payload, 32'hA1);
    check("skid_drain_occ", {30'd0, occupancy}, 32'd1);
    check("skid_in_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    check("skid_drain_a2", out_payload, 32'hA2);
    in_valid = 1'b0;
    tick();
    check("skid_empty", {30'd0, occupancy}, 32'd0);
    check("skid_stall_kept", {28'd0, stall_cycles}, 32'd2);

    // 4. Flush from FULL with a concurrent push
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = 32'hD0;
    tick();
    in_payload = 32'hD1;
    tick();
    check("flush_pre_full", {30'd0, occupancy}, 32'd2);
    in_payload = 32'hBB; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_occ", {30'd0, occupancy}, 32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_payload", out_payload, 32'h0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_stall_unaffected", {28'd0, stall_cycles}, 32'd4);
    out_ready = 1'b1;
    tick();
    check("flush_no_bb", {31'd0, out_valid}, 32'd0);
`else
    // 6. Single-entry combinational in_ready
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = 32'hC0;
    tick();
    in_payload = 32'hC1;
    #1;
    check("ns_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("ns_head_c0", out_payload, 32'hC0);
    out_ready = 1'b1;
    #1;
    check("ns_in_ready_high", {31'd0, in_ready}, 32'd1);
    tick();
    check("ns_capture_c1", out_payload, 32'hC1);
    check("ns_occ_one", {30'd0, occupancy}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("ns_drained", {30'd0, occupancy}, 32'd0);
    check("ns_stall", {28'd0, stall_cycles}, 32'd0);

    // 4. Flush from ONE with both handshakes firing
    in_valid = 1'b1; in_payload = 32'hF0;
    tick();
    in_payload = 32'hBB; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_occ", {30'd0, occupancy}, 32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_payload", out_payload, 32'h0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("flush_no_bb", {31'd0, out_valid}, 32'd0);
`endif

    // 5. Counter saturation and clear
    clr_cnt = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; in_payload = 32'hE0;
    tick();
    clr_cnt = 1'b0; in_valid = 1'b0;
    check("cnt_cleared", {28'd0, stall_cycles}, 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check("cnt_saturated", {28'd0, stall_cycles}, 32'd15);
    check("cnt_head_e0", out_payload, 32'hE0);
    clr_cnt = 1'b1;
    tick();
    check("cnt_clr_priority", {28'd0, stall_cycles}, 32'd0);
    clr_cnt = 1'b0;
    tick();
    check("cnt_resume", {28'd0, stall_cycles}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
